// File: rtl/pipe_controller_if.sv
// Handshake bundle between the LC-3 pipeline datapath (master) and pipe_controller (slave).
interface pipe_controller_if;
   logic        complete_data;
   logic        complete_instr;
   logic [15:0] IR;
   logic [15:0] IR_Exec;
   logic [2:0]  psr;

   logic        enable_updatePC;
   logic        enable_fetch;
   logic        enable_decode;
   logic        enable_execute;
   logic        enable_writeback;
   logic        br_taken;
   logic        bypass_alu_1;
   logic        bypass_alu_2;
   logic [1:0]  mem_state;

   modport master (
      output complete_data, complete_instr, IR, IR_Exec, psr,
      input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
             enable_writeback, br_taken, bypass_alu_1, bypass_alu_2, mem_state
   );

   modport slave (
      input  complete_data, complete_instr, IR, IR_Exec, psr,
      output enable_updatePC, enable_fetch, enable_decode, enable_execute,
             enable_writeback, br_taken, bypass_alu_1, bypass_alu_2, mem_state
   );
endinterface

// File: rtl/pipe_controller.sv
// Stage enables, control stall, ALU forwarding and data-memory sequencing for an LC-3 pipeline.
// Define LC3_INDIRECT_EN to give LDI/STI an indirect-address read; otherwise they behave as LD/ST.
module pipe_controller (
   input logic              clock,
   input logic              reset,
   pipe_controller_if.slave bus
);

   // state    | meaning
   // MEM_RD   | data read outstanding (LD/LDR, or final read of LDI)
   // MEM_IND  | indirect-address read outstanding (LDI/STI)
   // MEM_WR   | data write outstanding (ST/STR, or final write of STI)
   // MEM_IDLE | no data access; pipeline free to advance
   typedef enum logic [1:0] {
      MEM_RD   = 2'd0,
      MEM_IND  = 2'd1,
      MEM_WR   = 2'd2,
      MEM_IDLE = 2'd3
   } mem_state_t;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   localparam logic [1:0] STALL_LOAD = 2'd3;

   mem_state_t mem_state_q, mem_state_d;
   logic [1:0] stall_cnt_q, stall_cnt_d;
   logic       exec_pipe_q, exec_pipe_d;
   logic       wb_pipe_q, wb_pipe_d;
`ifdef LC3_INDIRECT_EN
   logic       ind_store_q, ind_store_d;
`endif

   logic [3:0] op_dec;
   logic [3:0] op_exec;
   logic       idle;
   logic       stall_active;
   logic       en_decode;
   logic       en_execute;
   logic       en_writeback;
   logic       br_cond;
   logic       exec_writes_alu;
   logic       dec_reads_src1;
   logic       dec_reads_src2;
   logic       unused_ir_bits;

   assign op_dec  = bus.IR[15:12];
   assign op_exec = bus.IR_Exec[15:12];
   assign unused_ir_bits = ^{bus.IR[11:9], bus.IR[4:3], bus.IR_Exec[8:0]};

   assign idle         = (mem_state_q == MEM_IDLE);
   assign stall_active = (stall_cnt_q != 2'd0);

   assign en_decode    = !reset && idle && !stall_active && bus.complete_instr;
   assign en_execute   = !reset && idle && exec_pipe_q;
   // Loads write back from the memory FSM; the enable pipeline is flushed while an access is outstanding.
   assign en_writeback = !reset &&
                         (idle ? wb_pipe_q : (mem_state_q == MEM_RD && bus.complete_data));

   assign br_cond = (op_exec == OP_JMP) ||
                    (op_exec == OP_BR && (bus.IR_Exec[11:9] & bus.psr) != 3'b000);

   assign exec_writes_alu = (op_exec == OP_ADD) || (op_exec == OP_AND) ||
                            (op_exec == OP_NOT) || (op_exec == OP_LEA);
   assign dec_reads_src1  = (op_dec == OP_ADD) || (op_dec == OP_AND) || (op_dec == OP_NOT) ||
                            (op_dec == OP_LDR) || (op_dec == OP_STR) || (op_dec == OP_JMP);
   assign dec_reads_src2  = ((op_dec == OP_ADD) || (op_dec == OP_AND)) && !bus.IR[5];

   assign bus.enable_updatePC  = en_decode;
   assign bus.enable_fetch     = en_decode;
   assign bus.enable_decode    = en_decode;
   assign bus.enable_execute   = en_execute;
   assign bus.enable_writeback = en_writeback;
   assign bus.br_taken         = !reset && idle && (stall_cnt_q == 2'd1) && br_cond;
   assign bus.bypass_alu_1     = !reset && exec_writes_alu && dec_reads_src1 &&
                                 (bus.IR_Exec[11:9] == bus.IR[8:6]);
   assign bus.bypass_alu_2     = !reset && exec_writes_alu && dec_reads_src2 &&
                                 (bus.IR_Exec[11:9] == bus.IR[2:0]);
   assign bus.mem_state        = mem_state_q;

   function automatic mem_state_t mem_entry(input logic [3:0] op);
      case (op)
         OP_LD, OP_LDR: mem_entry = MEM_RD;
         OP_ST, OP_STR: mem_entry = MEM_WR;
`ifdef LC3_INDIRECT_EN
         OP_LDI, OP_STI: mem_entry = MEM_IND;
`else
         OP_LDI: mem_entry = MEM_RD;
         OP_STI: mem_entry = MEM_WR;
`endif
         default: mem_entry = MEM_IDLE;
      endcase
   endfunction

   always_comb begin
      mem_state_d = mem_state_q;
      stall_cnt_d = stall_cnt_q;
      exec_pipe_d = exec_pipe_q;
      wb_pipe_d   = wb_pipe_q;
`ifdef LC3_INDIRECT_EN
      ind_store_d = ind_store_q;
`endif
      if (idle) begin
         exec_pipe_d = en_decode;
         wb_pipe_d   = exec_pipe_q;
         if (stall_active) begin
            stall_cnt_d = stall_cnt_q - 2'd1;
         end else if (en_decode && (op_dec == OP_BR || op_dec == OP_JMP)) begin
            stall_cnt_d = STALL_LOAD;
         end
         // A memory op in execute wins: the stall counter just loaded stays frozen until idle again.
         if (en_execute) begin
            mem_state_d = mem_entry(op_exec);
`ifdef LC3_INDIRECT_EN
            ind_store_d = (op_exec == OP_STI);
`endif
         end
      end else begin
         wb_pipe_d = 1'b0;
         if (bus.complete_data) begin
            case (mem_state_q)
               MEM_RD:  mem_state_d = MEM_IDLE;
               MEM_WR:  mem_state_d = MEM_IDLE;
`ifdef LC3_INDIRECT_EN
               MEM_IND: mem_state_d = ind_store_q ? MEM_WR : MEM_RD;
`endif
               default: mem_state_d = MEM_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_state_q <= MEM_IDLE;
         stall_cnt_q <= 2'd0;
         exec_pipe_q <= 1'b0;
         wb_pipe_q   <= 1'b0;
`ifdef LC3_INDIRECT_EN
         ind_store_q <= 1'b0;
`endif
      end else begin
         mem_state_q <= mem_state_d;
         stall_cnt_q <= stall_cnt_d;
         exec_pipe_q <= exec_pipe_d;
         wb_pipe_q   <= wb_pipe_d;
`ifdef LC3_INDIRECT_EN
         ind_store_q <= ind_store_d;
`endif
      end
   end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high; sampled on rising clock.
REQ-003 SHALL have port: complete_data  in  1  data memory access done this cycle.
REQ-004 SHALL have port: complete_instr  in  1  instruction memory fetch done this cycle.
REQ-005 SHALL have port: IR  in  16  instruction held by decode stage.
REQ-006 SHALL have port: IR_Exec  in  16  instruction held by execute stage.
REQ-007 SHALL have port: psr  in  3  NZP flags from writeback.
REQ-008 SHALL have ports: enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback  out  1 each  stage enables.
REQ-009 SHALL have port: br_taken  out  1  PC redirect this cycle.
REQ-010 SHALL have ports: bypass_alu_1, bypass_alu_2  out  1 each  forward execute ALU result to src1/src2.
REQ-011 SHALL have port: mem_state  out  2  memory FSM: 3 idle, 0 read, 1 indirect-address read, 2 write.

Function
REQ-012 Opcodes SHALL be: ALU = ADD 0001, AND 0101, NOT 1001; BR 0000; JMP 1100; LD 0010; LDR 0110; LDI 1010; LEA 1110; ST 0011; STR 0111; STI 1011.
REQ-013 Memory FSM SHALL leave idle on the cycle after IR_Exec holds a memory op with enable_execute=1: LD/LDR->0; ST/STR->2; LDI/STI->1.
REQ-014 Non-idle states SHALL advance only when complete_data=1: 0->3; 2->3; 1->0 for LDI and 1->2 for STI. If complete_data=0, the state SHALL hold indefinitely.
REQ-015 While mem_state!=3: enable_fetch, enable_decode, enable_execute and enable_updatePC SHALL be 0. enable_writeback SHALL be 1 only in state 0 with complete_data=1.
REQ-016 In idle with no control stall: enable_fetch, enable_updatePC and enable_decode SHALL equal complete_instr. enable_execute and enable_writeback SHALL be 1 one and two cycles after each decode enable, respectively (enable pipeline shift).
REQ-017 When IR holds BR or JMP with enable_decode=1, a control-stall counter SHALL load 3. While nonzero, enable_fetch, enable_updatePC and enable_decode SHALL be 0 and the counter SHALL decrement each cycle. Fetch SHALL resume on the cycle the counter reaches 0.
REQ-018 br_taken SHALL be 1 for exactly one cycle when the control-stall counter equals 1 and IR_Exec is JMP, or IR_Exec is BR with (IR_Exec[11:9] & psr) != 0. Otherwise br_taken SHALL be 0; BR with nzp=000 SHALL never be taken.
REQ-019 bypass_alu_1 SHALL be 1 iff IR_Exec is ALU or LEA, IR is ALU/LDR/STR/JMP, and IR_Exec[11:9]==IR[8:6].
REQ-020 bypass_alu_2 SHALL be 1 iff IR_Exec is ALU or LEA, IR is ADD/AND with IR[5]=0, and IR_Exec[11:9]==IR[2:0]. Both bypasses SHALL be 0 when IR_Exec is a load.
REQ-021 A memory op SHALL take precedence over a control stall in the same cycle. The control-stall counter SHALL freeze while mem_state!=3.

Reset
REQ-022 On reset=1 at a clock edge, the controller SHALL set: mem_state=3, control-stall counter=0, enable pipeline cleared, all enables=0, br_taken=0, bypasses=0.
REQ-023 Reset asserted mid-access or mid-stall SHALL abort the operation. The first enable_fetch SHALL follow the first cycle after reset deasserts with complete_instr=1.

Configuration
REQ-024 Macro LC3_INDIRECT_EN SHALL control indirect memory support.
- Defined: LDI/STI SHALL use state 1 per REQ-013/014.
- Undefined: LDI SHALL behave as LD, STI SHALL behave as ST, and state 1 SHALL be unreachable.

Verification
REQ-025 Reset pulse, then complete_instr=1 -> mem_state=3, enable_fetch=1 from the first post-reset cycle; enable_execute follows 1 cycle later and enable_writeback 2 cycles later.
REQ-026 IR_Exec=LDI (0xA200), complete_data=1 on 2nd access cycle only -> mem_state 3,1,1,0,3 (complete_data=1 on the 0-state cycle); enable_writeback=1 only on that cycle.
REQ-027 IR=BRz (0x0402) decoded, psr=010 -> fetch disabled 3 cycles, br_taken=1 once; repeat with psr=100 -> br_taken=0.
REQ-028 IR_Exec=ADD R3 (0x16C1), IR=ADD R1,R3,R3 (0x12C3) -> bypass_alu_1=1, bypass_alu_2=1. IR_Exec=LDR R3 -> both 0.
REQ-029 ST with complete_data held 0 for 5 cycles -> mem_state=2 for those 5 cycles, then 3; all enables 0 meanwhile. Reset during the hold -> mem_state=3 next cycle.
REQ-030 Build without LC3_INDIRECT_EN, IR_Exec=STI -> mem_state 3,2,3; state 1 is never observed.
